// File: rtl/aes_encr_iter.sv
// Iterative AES-128 encryption core: one cipher round per clock with on-the-fly key expansion.
// Blocks enter and ciphertext leaves through valid/ready handshakes; [127:120] is byte 0, column-major.
module aes_encr_iter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ip_data,
  input  logic [127:0] ip_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] encr_data_out,
  output logic         busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  typedef logic [DATA_WIDTH-1:0] lane_t;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x sits at bit offset 8*(255-x), and 255-x is simply ~x.
  function automatic lane_t sbox(input lane_t x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic lane_t xtime(input lane_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [1:0]   fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rkey_q, rkey_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] dout_q, dout_d;
  logic         ovalid_q, ovalid_d;

  logic [0:15][7:0] st, sb, sr, mc;
  logic [31:0]      kt, n0, n1, n2, n3;
  logic [127:0]     nkey, rnd_res;
  logic             last_rnd;
  lane_t            a0, a1, a2, a3;

  always_comb begin
    st = state_q;
    sb = '0;
    sr = '0;
    mc = '0;
    a0 = '0;
    a1 = '0;
    a2 = '0;
    a3 = '0;
    for (int unsigned i = 0; i < 16; i++) sb[4'(i)] = sbox(st[4'(i)]);
    // Row r of column c takes the byte from column (c+r) mod 4.
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        sr[4'(4*c+r)] = sb[4'(4*((c+r)%4)+r)];
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = sr[4'(4*c)];
      a1 = sr[4'(4*c+1)];
      a2 = sr[4'(4*c+2)];
      a3 = sr[4'(4*c+3)];
      mc[4'(4*c)]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mc[4'(4*c+1)] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mc[4'(4*c+2)] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mc[4'(4*c+3)] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    kt = {sbox(rkey_q[23:16]), sbox(rkey_q[15:8]), sbox(rkey_q[7:0]), sbox(rkey_q[31:24])}
         ^ {rcon_q, 24'h000000};
    n0 = rkey_q[127:96] ^ kt;
    n1 = rkey_q[95:64] ^ n0;
    n2 = rkey_q[63:32] ^ n1;
    n3 = rkey_q[31:0] ^ n2;
    nkey = {n0, n1, n2, n3};
    last_rnd = (rnd_q == 4'(NUM_ROUNDS));
    rnd_res = (last_rnd ? sr : mc) ^ nkey;
  end

  always_comb begin
    fsm_d    = fsm_q;
    state_d  = state_q;
    rkey_d   = rkey_q;
    rcon_d   = rcon_q;
    rnd_d    = rnd_q;
    dout_d   = dout_q;
    ovalid_d = ovalid_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d = ip_data ^ ip_key;
          rkey_d  = ip_key;
          rcon_d  = 8'h01;
          rnd_d   = 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        state_d = rnd_res;
        rkey_d  = nkey;
        rcon_d  = xtime(rcon_q);
        rnd_d   = rnd_q + 4'd1;
        if (last_rnd) begin
          dout_d   = rnd_res;
          ovalid_d = 1'b1;
          fsm_d    = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          ovalid_d = 1'b0;
          fsm_d    = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q    <= IDLE;
      state_q  <= '0;
      rkey_q   <= '0;
      rcon_q   <= '0;
      rnd_q    <= '0;
      dout_q   <= '0;
      ovalid_q <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      state_q  <= state_d;
      rkey_q   <= rkey_d;
      rcon_q   <= rcon_d;
      rnd_q    <= rnd_d;
      dout_q   <= dout_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign in_ready      = (fsm_q == IDLE);
  assign busy          = (fsm_q == ROUND) || (fsm_q == DONE);
  assign out_valid     = ovalid_q;
  assign encr_data_out = dout_q;

endmodule

// File: tb/tb_aes_encr_iter.sv
// Bench for aes_encr_iter: a textbook AES-128 reference (S-box derived from the GF(2^8) inverse)
// plus a transaction-level timing model, compared against the DUT on every falling edge.
module tb_aes_encr_iter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] ip_data = '0;
  logic [127:0] ip_key = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] encr_data_out;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  logic [7:0] sb_t [256];

  aes_encr_iter #(.DATA_WIDTH(8), .NUM_ROUNDS(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ip_data(ip_data), .ip_key(ip_key), .out_valid(out_valid), .out_ready(out_ready),
    .encr_data_out(encr_data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb_t[w[31:24]], sb_t[w[23:16]], sb_t[w[15:8]], sb_t[w[7:0]]};
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc, x0, x1, x2, x3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) b[i] = pt[127-8*i -: 8];
    for (int i = 0; i < 16; i++) b[i] ^= w[i/4][31-8*(i%4) -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int i = 0; i < 16; i++) b[i] = sb_t[b[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = b[4*((c+r)%4)+r];
      b = t;
      if (rd < 10)
        for (int c = 0; c < 4; c++) begin
          x0 = b[4*c]; x1 = b[4*c+1]; x2 = b[4*c+2]; x3 = b[4*c+3];
          b[4*c]   = gmul(x0, 8'h02) ^ gmul(x1, 8'h03) ^ x2 ^ x3;
          b[4*c+1] = x0 ^ gmul(x1, 8'h02) ^ gmul(x2, 8'h03) ^ x3;
          b[4*c+2] = x0 ^ x1 ^ gmul(x2, 8'h02) ^ gmul(x3, 8'h03);
          b[4*c+3] = gmul(x0, 8'h03) ^ x1 ^ x2 ^ gmul(x3, 8'h02);
        end
      for (int i = 0; i < 16; i++) b[i] ^= w[4*rd + i/4][31-8*(i%4) -: 8];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = b[i];
    return res;
  endfunction

  // Transaction model: idle until an accept, result visible 10 edges later, held until out_ready.
  logic         m_armed = 1'b0;
  logic         m_idle  = 1'b1;
  logic         m_outv  = 1'b0;
  int           m_age   = 0;
  logic [127:0] m_ct    = '0;
  logic [127:0] m_out   = '0;

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (rst) begin
      m_armed <= 1'b1;
      m_idle  <= 1'b1;
      m_outv  <= 1'b0;
      m_age   <= 0;
      m_out   <= '0;
    end else if (m_armed) begin
      if (m_idle) begin
        if (in_valid) begin
          m_idle <= 1'b0;
          m_age  <= 0;
          m_ct   <= aes_ref(ip_data, ip_key);
        end
      end else if (!m_outv) begin
        m_age <= m_age + 1;
        if (m_age + 1 == 10) begin
          m_outv <= 1'b1;
          m_out  <= m_ct;
        end
      end else if (out_ready) begin
        m_outv <= 1'b0;
        m_idle <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_armed) begin
      chk("in_ready", 128'(in_ready), 128'(m_idle));
      chk("busy", 128'(busy), 128'(!m_idle));
      chk("out_valid", 128'(out_valid), 128'(m_outv));
      chk("encr_data_out", encr_data_out, m_out);
    end
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send(input logic [127:0] pt, input logic [127:0] key, output int acc);
    ip_data = pt;
    ip_key = key;
    in_valid = 1'b1;
    acc = -1;
    for (int k = 0; k < 40; k++) begin
      if (in_ready) begin
        @(posedge clk);
        @(negedge clk);
        acc = cyc_n;
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    ip_data = rnd128();
    ip_key = rnd128();
    if (acc < 0) chk("accept_timeout", 128'(0), 128'(1));
  endtask

  task automatic wait_out(input int acc, output logic [127:0] ct, output int lat);
    logic found;
    found = 1'b0;
    ct = '0;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) begin
        found = 1'b1;
        ct = encr_data_out;
        lat = cyc_n - acc;
        break;
      end
      @(negedge clk);
    end
    if (!found) chk("out_valid_timeout", 128'(0), 128'(1));
  endtask

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P5  = 128'h5D6F56A334379DCD02160A24B98EA22D;
  localparam logic [127:0] K5  = 128'hFE657897FFEA567645AEDECD56891267;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, lat, prev, gaps;
    logic [127:0] ct, pt, key;

    build_sbox();
    chk("model_sbox_00", 128'(sb_t[8'h00]), 128'(8'h63));
    chk("model_sbox_53", 128'(sb_t[8'h53]), 128'(8'hed));
    chk("model_fips_c1", aes_ref(P1, K1), C1);
    chk("model_fips_b", aes_ref(P2, K2), C2);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_data", encr_data_out, '0);

    // FIPS-197 C.1 with latency
    out_ready = 1'b1;
    send(P1, K1, acc);
    wait_out(acc, ct, lat);
    chk("ct_c1", ct, C1);
    chk("latency_c1", 128'(lat), 128'(10));
    @(negedge clk);

    // FIPS-197 App.B under 20 cycles of backpressure
    out_ready = 1'b0;
    send(P2, K2, acc);
    wait_out(acc, ct, lat);
    chk("ct_appb", ct, C2);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("bp_data_stable", encr_data_out, C2);
      chk("bp_out_valid", 128'(out_valid), 128'(1));
      chk("bp_in_ready", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_idle", 128'(in_ready), 128'(1));
    chk("bp_release_valid", 128'(out_valid), 128'(0));

    // Reset landing on round 5, then rerun C.1
    send(P1, K1, acc);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_data", encr_data_out, '0);
    chk("midrst_busy", 128'(busy), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    send(P1, K1, acc);
    wait_out(acc, ct, lat);
    chk("ct_after_rst", ct, C1);
    @(negedge clk);

    // Loopback vector
    send(P5, K5, acc);
    wait_out(acc, ct, lat);
    chk("ct_loopback", ct, aes_ref(P5, K5));
    repeat (2) @(negedge clk);

    // Back-to-back with in_valid held high and inputs changing every cycle
    out_ready = 1'b1;
    in_valid = 1'b1;
    prev = -1;
    gaps = 0;
    for (int k = 0; k < 62; k++) begin
      @(negedge clk);
      if (in_ready) begin
        if (prev >= 0) begin
          chk("b2b_interval", 128'(cyc_n - prev), 128'(12));
          gaps++;
        end
        prev = cyc_n;
      end
      ip_data = rnd128();
      ip_key = rnd128();
    end
    in_valid = 1'b0;
    chk("b2b_accept_count", 128'(gaps >= 4), 128'(1));
    repeat (14) @(negedge clk);

    // Random blocks with random idle gaps and sink delays
    for (int n = 0; n < 6; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      pt = rnd128();
      key = rnd128();
      send(pt, key, acc);
      wait_out(acc, ct, lat);
      chk("ct_random", ct, aes_ref(pt, key));
      chk("latency_random", 128'(lat), 128'(10));
      out_ready = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
